// File: rtl/mesi_cbus_snoop.sv
// Cache-side coherence bus responder: keeps a direct-mapped MESI state/tag table,
// writes back Modified lines on snoop hits and grants local CPU accesses.
module mesi_cbus_snoop #(
  parameter int unsigned CBUS_CMD_WIDTH = 3,
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned NUM_LINES_LOG2 = 4,
  parameter int unsigned LINE_OFFSET    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic                      wb_req_o,
  output logic [ADDR_WIDTH-1:0]     wb_addr_o,
  input  logic                      wb_ack_i,
  output logic                      en_wr_o,
  output logic                      en_rd_o,
  input  logic                      cpu_done_i,
  input  logic                      upd_valid_i,
  input  logic [ADDR_WIDTH-1:0]     upd_addr_i,
  input  logic [1:0]                upd_state_i,
  output logic                      upd_ready_o
);

  localparam int unsigned NumLines = 1 << NUM_LINES_LOG2;
  localparam int unsigned TagW     = ADDR_WIDTH - NUM_LINES_LOG2 - LINE_OFFSET;
  localparam logic [ADDR_WIDTH-1:0] OffMask = ADDR_WIDTH'((64'd1 << LINE_OFFSET) - 64'd1);

  localparam logic [CBUS_CMD_WIDTH-1:0] CmdNop     = CBUS_CMD_WIDTH'(0);
  localparam logic [CBUS_CMD_WIDTH-1:0] CmdWrSnoop = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CmdRdSnoop = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnWr    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CmdEnRd    = CBUS_CMD_WIDTH'(4);

  localparam logic [1:0] MesiI = 2'd0;
  localparam logic [1:0] MesiS = 2'd1;
  localparam logic [1:0] MesiE = 2'd2;
  localparam logic [1:0] MesiM = 2'd3;

  typedef enum logic [2:0] {StIdle, StLookup, StWbReq, StEnWait, StAck} state_e;

  state_e                    state_q, state_d;
  logic [CBUS_CMD_WIDTH-1:0] cmd_q;
  logic [ADDR_WIDTH-1:0]     addr_q;
  logic                      ack_q, ack_d;
  logic [1:0]                wb_final_q, wb_final_d;
  logic [1:0]                mesi_q [NumLines];
  logic [TagW-1:0]           tag_q  [NumLines];

  logic                      accept;
  logic                      tbl_we;
  logic [NUM_LINES_LOG2-1:0] tbl_idx;
  logic [TagW-1:0]           tbl_tag;
  logic [1:0]                tbl_state;

  logic [NUM_LINES_LOG2-1:0] lk_idx, upd_idx;
  logic [TagW-1:0]           lk_tag, upd_tag;
  logic                      hit;
  logic [1:0]                lk_state;

  assign lk_idx   = NUM_LINES_LOG2'(addr_q >> LINE_OFFSET);
  assign lk_tag   = TagW'(addr_q >> (LINE_OFFSET + NUM_LINES_LOG2));
  assign upd_idx  = NUM_LINES_LOG2'(upd_addr_i >> LINE_OFFSET);
  assign upd_tag  = TagW'(upd_addr_i >> (LINE_OFFSET + NUM_LINES_LOG2));
  assign lk_state = mesi_q[lk_idx];
  assign hit      = (lk_state != MesiI) && (tag_q[lk_idx] == lk_tag);

  always_comb begin
    state_d     = state_q;
    wb_final_d  = wb_final_q;
    accept      = 1'b0;
    tbl_we      = 1'b0;
    tbl_idx     = lk_idx;
    tbl_tag     = lk_tag;
    tbl_state   = MesiI;
    en_wr_o     = 1'b0;
    en_rd_o     = 1'b0;
    upd_ready_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cbus_cmd_i != CmdNop) begin
          accept  = 1'b1;
          state_d = StLookup;
        end else begin
          // Gated by reset so every output reads 0 while reset is held
          upd_ready_o = rst;
          if (upd_valid_i) begin
            tbl_we    = 1'b1;
            tbl_idx   = upd_idx;
            tbl_tag   = upd_tag;
            tbl_state = upd_state_i;
          end
        end
      end
      StLookup: begin
        state_d = StAck;
        case (cmd_q)
          CmdWrSnoop: begin
            if (hit && lk_state == MesiM) begin
              wb_final_d = MesiI;
              state_d    = StWbReq;
            end else if (hit) begin
              tbl_we    = 1'b1;
              tbl_state = MesiI;
            end
          end
          CmdRdSnoop: begin
            if (hit && lk_state == MesiM) begin
              wb_final_d = MesiS;
              state_d    = StWbReq;
            end else if (hit && lk_state == MesiE) begin
              tbl_we    = 1'b1;
              tbl_state = MesiS;
            end
          end
          CmdEnWr: begin
            en_wr_o = 1'b1;
            state_d = StEnWait;
          end
          CmdEnRd: begin
            en_rd_o = 1'b1;
            state_d = StEnWait;
          end
          default: ;
        endcase
      end
      StWbReq: begin
        if (wb_ack_i) begin
          tbl_we    = 1'b1;
          tbl_state = wb_final_q;
          state_d   = StAck;
        end
      end
      StEnWait: begin
        if (cpu_done_i) state_d = StAck;
      end
      StAck: begin
        if (ack_q && cbus_cmd_i == CmdNop) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Ack rises one cycle after entering StAck and falls with the NOP that releases it
  assign ack_d      = (state_q == StAck) && !(ack_q && cbus_cmd_i == CmdNop);
  assign cbus_ack_o = ack_q;
  assign wb_req_o   = (state_q == StWbReq);
  assign wb_addr_o  = wb_req_o ? (addr_q & ~OffMask) : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      cmd_q      <= CmdNop;
      addr_q     <= '0;
      ack_q      <= 1'b0;
      wb_final_q <= MesiI;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      wb_final_q <= wb_final_d;
      if (accept) begin
        cmd_q  <= cbus_cmd_i;
        addr_q <= cbus_addr_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NumLines; i++) begin
        mesi_q[i] <= MesiI;
        tag_q[i]  <= '0;
      end
    end else if (tbl_we) begin
      mesi_q[tbl_idx] <= tbl_state;
      tag_q[tbl_idx]  <= tbl_tag;
    end
  end

endmodule
